// File: rtl/load_align_unit_pkg.sv
// rtl/load_align_unit_pkg.sv - load funct3 codes, FSM states and size/legality helpers
package load_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        WT0,
        RD1,
        WT1,
        RESP
    } state_t;

    // Access size in bytes; zero for the reserved encoding.
    function automatic logic [3:0] load_size(input logic [2:0] funct3);
        case (funct3)
            LB, LBU: load_size = 4'd1;
            LH, LHU: load_size = 4'd2;
            LW, LWU: load_size = 4'd4;
            LD:      load_size = 4'd8;
            default: load_size = 4'd0;
        endcase
    endfunction

    function automatic logic load_legal(input logic [2:0] funct3, input int xlen);
        case (funct3)
            LB, LH, LW, LBU, LHU: load_legal = 1'b1;
            LD, LWU:              load_legal = (xlen == 64);
            default:              load_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align_unit_if.sv
// rtl/load_align_unit_if.sv - request, memory-port and response handshake bundle
interface load_align_unit_if #(parameter int XLEN = 32) ();

    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_addr;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rdata;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_err;
    logic            misaligned;

    modport master (
        output req_valid, req_funct3, req_addr,
        output mem_req_ready, mem_rsp_valid, mem_rdata,
        output rsp_ready,
        input  req_ready, mem_req_valid, mem_addr,
        input  rsp_valid, rsp_data, rsp_err, misaligned
    );

    modport slave (
        input  req_valid, req_funct3, req_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rdata,
        input  rsp_ready,
        output req_ready, mem_req_valid, mem_addr,
        output rsp_valid, rsp_data, rsp_err, misaligned
    );

endinterface

// File: rtl/load_align_unit_extract.sv
// rtl/load_align_unit_extract.sv - shifts merged read data to the addressed byte and extends it
module load_extract
    import load_pkg::*;
#(
    parameter int  XLEN = 32,
    localparam int OFFW = $clog2(XLEN / 8)
) (
    input  logic [2*XLEN-1:0] merged,
    input  logic [OFFW-1:0]   off,
    input  logic [2:0]        funct3,
    output logic [XLEN-1:0]   data
);

    logic [XLEN-1:0] shifted;

    assign shifted = XLEN'(merged >> {off, 3'b000});

    always_comb begin
        data = '0;
        case (funct3)
            LB:      data = XLEN'($signed(shifted[7:0]));
            LBU:     data = XLEN'(shifted[7:0]);
            LH:      data = XLEN'($signed(shifted[15:0]));
            LHU:     data = XLEN'(shifted[15:0]);
            LW:      data = XLEN'($signed(shifted[31:0]));
            LWU:     data = XLEN'(shifted[31:0]);
            LD:      data = shifted;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// rtl/load_align_unit.sv - load path FSM issuing one or two aligned reads per request
module load_align_unit
    import load_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic              clk,
    input logic              reset,
    load_align_unit_if.slave bus
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    state_t          state_q, state_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] word0_q, word0_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
    logic            misal_q, misal_d;
    logic            rsp_err_q, rsp_err_d;

    logic [XLEN-1:0]   base;
    logic [XLEN-1:0]   base_next;
    logic [2*XLEN-1:0] merged;
    logic [XLEN-1:0]   extracted;
    logic              req_misal;

    assign base      = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign base_next = base + XLEN'(NB);
    assign req_misal = (5'(bus.req_addr[OFFW-1:0]) + 5'(load_size(bus.req_funct3))) > 5'(NB);

    // Aligned loads see only word0 (arriving now); the high word is zero.
    assign merged = (state_q == WT1) ? {bus.mem_rdata, word0_q}
                                     : {{XLEN{1'b0}}, bus.mem_rdata};

    load_extract #(.XLEN(XLEN)) u_extract (
        .merged (merged),
        .off    (addr_q[OFFW-1:0]),
        .funct3 (funct3_q),
        .data   (extracted)
    );

    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.misaligned = misal_q && (state_q != IDLE);

    always_comb begin
        state_d           = state_q;
        funct3_d          = funct3_q;
        addr_d            = addr_q;
        word0_d           = word0_q;
        rsp_data_d        = rsp_data_q;
        misal_d           = misal_q;
        rsp_err_d         = rsp_err_q;
        bus.req_ready     = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.mem_addr      = '0;
        bus.rsp_valid     = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    misal_d  = req_misal;
                    if (load_legal(bus.req_funct3, XLEN)) begin
                        rsp_err_d = 1'b0;
                        state_d   = RD0;
                    end else begin
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                        state_d    = RESP;
                    end
                end
            end
            RD0: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_addr      = base;
                if (bus.mem_req_ready) state_d = WT0;
            end
            WT0: begin
                if (bus.mem_rsp_valid) begin
                    word0_d = bus.mem_rdata;
                    if (misal_q) begin
                        state_d = RD1;
                    end else begin
                        rsp_data_d = extracted;
                        state_d    = RESP;
                    end
                end
            end
            RD1: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_addr      = base_next;
                if (bus.mem_req_ready) state_d = WT1;
            end
            WT1: begin
                if (bus.mem_rsp_valid) begin
                    rsp_data_d = extracted;
                    state_d    = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            funct3_q   <= '0;
            addr_q     <= '0;
            word0_q    <= '0;
            rsp_data_q <= '0;
            misal_q    <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            word0_q    <= word0_d;
            rsp_data_q <= rsp_data_d;
            misal_q    <= misal_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// tb/tb_load_align_unit.sv - scoreboard bench driving XLEN=32 and XLEN=64 instances
module tb_load_align_unit;
    import load_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    load_align_unit_if #(.XLEN(32)) if32 ();
    load_align_unit_if #(.XLEN(64)) if64 ();

    load_align_unit #(.XLEN(32)) u32 (.clk(clk), .reset(reset), .bus(if32.slave));
    load_align_unit #(.XLEN(64)) u64 (.clk(clk), .reset(reset), .bus(if64.slave));

    logic        sel;
    logic        req_valid;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [63:0] mem_rdata;
    logic        rsp_ready;

    assign if32.req_valid     = req_valid & ~sel;
    assign if32.req_funct3    = req_funct3;
    assign if32.req_addr      = req_addr[31:0];
    assign if32.mem_req_ready = mem_req_ready & ~sel;
    assign if32.mem_rsp_valid = mem_rsp_valid & ~sel;
    assign if32.mem_rdata     = mem_rdata[31:0];
    assign if32.rsp_ready     = rsp_ready & ~sel;
    assign if64.req_valid     = req_valid & sel;
    assign if64.req_funct3    = req_funct3;
    assign if64.req_addr      = req_addr;
    assign if64.mem_req_ready = mem_req_ready & sel;
    assign if64.mem_rsp_valid = mem_rsp_valid & sel;
    assign if64.mem_rdata     = mem_rdata;
    assign if64.rsp_ready     = rsp_ready & sel;

    logic        o_req_ready, o_mem_req_valid, o_rsp_valid, o_rsp_err, o_misaligned;
    logic [63:0] o_mem_addr, o_rsp_data;
    assign o_req_ready     = sel ? if64.req_ready     : if32.req_ready;
    assign o_mem_req_valid = sel ? if64.mem_req_valid : if32.mem_req_valid;
    assign o_rsp_valid     = sel ? if64.rsp_valid     : if32.rsp_valid;
    assign o_rsp_err       = sel ? if64.rsp_err       : if32.rsp_err;
    assign o_misaligned    = sel ? if64.misaligned    : if32.misaligned;
    assign o_mem_addr      = sel ? if64.mem_addr      : {32'h0, if32.mem_addr};
    assign o_rsp_data      = sel ? if64.rsp_data      : {32'h0, if32.rsp_data};

    typedef struct {
        logic [63:0] data;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        req_valid     = 1'b0;
        req_funct3    = 3'b000;
        req_addr      = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        rsp_ready     = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ":req_ready"}, 64'(o_req_ready), 64'd1);
        check_eq({tag, ":mem_req_valid"}, 64'(o_mem_req_valid), 64'd0);
        check_eq({tag, ":rsp_valid"}, 64'(o_rsp_valid), 64'd0);
        check_eq({tag, ":rsp_err"}, 64'(o_rsp_err), 64'd0);
        check_eq({tag, ":misaligned"}, 64'(o_misaligned), 64'd0);
        check_eq({tag, ":rsp_data"}, o_rsp_data, 64'd0);
        check_eq({tag, ":mem_addr"}, o_mem_addr, 64'd0);
    endtask

    // One load: serves reads from w0/w1, stalls as asked, checks addresses,
    // latency and the scoreboard entry pushed at issue.
    task automatic run_load(input logic s, input logic [2:0] f3, input logic [63:0] addr,
                            input logic [63:0] w0, input logic [63:0] w1,
                            input logic [63:0] exp_data, input int rd_stall,
                            input int rsp_stall, input string tag);
        int nb, sz, off, lat, exp_lat, nreads, stall_left, hold_left, exp_reads;
        logic mis, legal, pend, done, seen;
        logic [63:0] amask, base, a1;
        exp_t e;
        nb    = s ? 8 : 4;
        amask = s ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        case (f3)
            3'b000, 3'b100: sz = 1;
            3'b001, 3'b101: sz = 2;
            3'b010:         sz = 4;
            3'b110:         sz = s ? 4 : 0;
            3'b011:         sz = s ? 8 : 0;
            default:        sz = 0;
        endcase
        legal     = (sz != 0);
        off       = int'(addr[2:0]) & (nb - 1);
        mis       = legal && (off + sz > nb);
        base      = addr & ~64'(nb - 1);
        a1        = (base + 64'(nb)) & amask;
        exp_lat   = !legal ? 1 : ((mis ? 5 : 3) + rd_stall);
        exp_reads = !legal ? 0 : (mis ? 2 : 1);
        e.data = exp_data;
        e.err  = !legal;
        sb_q.push_back(e);

        @(negedge clk);
        sel = s;
        #1;
        check_eq({tag, ":req_ready"}, 64'(o_req_ready), 64'd1);
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_addr   = addr;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1; nreads = 0; pend = 1'b0; done = 1'b0; seen = 1'b0;
        stall_left = rd_stall; hold_left = rsp_stall;
        while (!done && lat < 60) begin
            @(negedge clk);
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            rsp_ready     = 1'b0;
            if (pend) begin
                mem_rsp_valid = 1'b1;
                mem_rdata     = (nreads == 1) ? w0 : w1;
                pend          = 1'b0;
            end
            #1;
            if (o_mem_req_valid) begin
                check_eq({tag, ":mem_addr"}, o_mem_addr, (nreads == 0) ? base : a1);
                check_eq({tag, ":misaligned_busy"}, 64'(o_misaligned), 64'(mis));
                if (nreads == 0 && stall_left > 0) begin
                    stall_left--;
                end else begin
                    mem_req_ready = 1'b1;
                    nreads++;
                    pend = 1'b1;
                end
            end
            if (o_rsp_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    check_eq({tag, ":latency"}, 64'(lat), 64'(exp_lat));
                end
                check_eq({tag, ":req_ready_in_resp"}, 64'(o_req_ready), 64'd0);
                if (hold_left > 0) begin
                    check_eq({tag, ":rsp_data_hold"}, o_rsp_data, exp_data);
                    hold_left--;
                end else begin
                    rsp_ready = 1'b1;
                    if (sb_q.size() == 0) begin
                        check_eq({tag, ":scoreboard_empty"}, 64'd1, 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check_eq({tag, ":rsp_data"}, o_rsp_data, e.data);
                        check_eq({tag, ":rsp_err"}, 64'(o_rsp_err), 64'(e.err));
                    end
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, ":completed"}, 64'(done), 64'd1);
        check_eq({tag, ":reads"}, 64'(nreads), 64'(exp_reads));
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        sel = 1'b0;
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset32");
        sel = 1'b1;
        #1;
        check_reset_outputs("reset64");
        sel = 1'b0;

        run_load(1'b0, LW,     64'h100,      64'h8899AABB, 64'h0, 64'h8899AABB, 0, 0, "lw_aligned");
        run_load(1'b0, LB,     64'h103,      64'h80112233, 64'h0, 64'hFFFFFF80, 0, 0, "lb_0x103");
        run_load(1'b0, LBU,    64'h102,      64'h80112233, 64'h0, 64'h00000011, 0, 0, "lbu_0x102");
        run_load(1'b0, LHU,    64'h102,      64'h80112233, 64'h0, 64'h00008011, 0, 0, "lhu_0x102");
        run_load(1'b0, LH,     64'h103,      64'h80112233, 64'h445566F7, 64'hFFFFF780, 0, 0, "lh_split");
        run_load(1'b0, LW,     64'hFFFFFFFE, 64'hAABBCCDD, 64'h11223344, 64'h3344AABB, 0, 0, "lw_wrap");
        run_load(1'b0, 3'b011, 64'h100,      64'h0, 64'h0, 64'h0, 0, 0, "ld_on_32");
        run_load(1'b0, 3'b111, 64'h100,      64'h0, 64'h0, 64'h0, 0, 0, "f3_111");
        run_load(1'b0, LW,     64'h100,      64'hCAFEF00D, 64'h0, 64'hCAFEF00D, 3, 2, "lw_stall");

        run_load(1'b1, LD,     64'h8, 64'h8000000000000001, 64'h0, 64'h8000000000000001, 0, 0, "ld_64");
        run_load(1'b1, LW,     64'hC, 64'hFFFFFFFF00000000, 64'h0, 64'hFFFFFFFFFFFFFFFF, 0, 0, "lw_64");
        run_load(1'b1, LWU,    64'hC, 64'hFFFFFFFF00000000, 64'h0, 64'h00000000FFFFFFFF, 0, 0, "lwu_64");
        run_load(1'b1, LW,     64'h6, 64'h1122334455667788, 64'h99AABBCCDDEEFF00,
                 64'hFFFFFFFFFF001122, 0, 0, "lw_split_64");
        run_load(1'b1, 3'b111, 64'h0, 64'h0, 64'h0, 64'h0, 0, 0, "f3_111_64");

        // Reset while waiting for the second word of a split lh.
        @(negedge clk);
        sel        = 1'b0;
        req_valid  = 1'b1;
        req_funct3 = LH;
        req_addr   = 64'h103;
        @(posedge clk); #1; req_valid = 1'b0;
        @(negedge clk); mem_req_ready = 1'b1;
        @(posedge clk); #1; mem_req_ready = 1'b0;
        @(negedge clk); mem_rsp_valid = 1'b1; mem_rdata = 64'h80112233;
        @(posedge clk); #1; mem_rsp_valid = 1'b0;
        @(negedge clk);
        check_eq("rst_mid:rd1_addr", o_mem_addr, 64'h104);
        mem_req_ready = 1'b1;
        @(posedge clk); #1; mem_req_ready = 1'b0;
        @(negedge clk);
        check_eq("rst_mid:misaligned_wt1", 64'(o_misaligned), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        mem_rsp_valid = 1'b1;
        mem_rdata     = 64'h445566F7;
        @(posedge clk); #1; mem_rsp_valid = 1'b0;
        @(negedge clk);
        check_eq("late_rsp:rsp_valid", 64'(o_rsp_valid), 64'd0);
        check_eq("late_rsp:req_ready", 64'(o_req_ready), 64'd1);
        check_eq("late_rsp:rsp_data", o_rsp_data, 64'd0);

        run_load(1'b0, LW, 64'h200, 64'h12345678, 64'h0, 64'h12345678, 0, 0, "lw_after_reset");

        check_eq("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
